// File: rtl/agc_io_pkg.sv
// Shared AGC I/O definitions: DSKY key codes, channel 015 word layout,
// key validity check and the keyboard encoder FSM state encodings.
package agc_io_pkg;

  localparam int unsigned AGC_WORD_W = 15;
  localparam int unsigned KEY_CODE_W = 5;

  localparam logic [AGC_WORD_W-1:0] CHAN15_ADDR = 15'o15;

  // DSKY keypad codes as seen on channel 015
  localparam logic [KEY_CODE_W-1:0] KEY_1     = 5'd1;
  localparam logic [KEY_CODE_W-1:0] KEY_9     = 5'd9;
  localparam logic [KEY_CODE_W-1:0] KEY_0     = 5'd16;
  localparam logic [KEY_CODE_W-1:0] KEY_VERB  = 5'd17;
  localparam logic [KEY_CODE_W-1:0] KEY_RSET  = 5'd18;
  localparam logic [KEY_CODE_W-1:0] KEY_REL   = 5'd25;
  localparam logic [KEY_CODE_W-1:0] KEY_PLUS  = 5'd26;
  localparam logic [KEY_CODE_W-1:0] KEY_MINUS = 5'd27;
  localparam logic [KEY_CODE_W-1:0] KEY_ENTR  = 5'd28;
  localparam logic [KEY_CODE_W-1:0] KEY_CLR   = 5'd30;
  localparam logic [KEY_CODE_W-1:0] KEY_NOUN  = 5'd31;

  // Channel 015 word: key code in the low bits, upper bits always zero
  typedef struct packed {
    logic [AGC_WORD_W-KEY_CODE_W-1:0] pad;
    logic [KEY_CODE_W-1:0]            code;
  } chan15_word_t;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_ARM,
    DB_HELD,
    DB_RELEASE
  } db_state_e;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_REQ,
    HS_GAP
  } hs_state_e;

  // True for codes that correspond to a physical DSKY key
  function automatic logic is_valid_key(input logic [KEY_CODE_W-1:0] code);
    logic ok;
    ok = 1'b0;
    if ((code >= KEY_1) && (code <= KEY_9)) ok = 1'b1;
    case (code)
      KEY_0, KEY_VERB, KEY_RSET, KEY_REL, KEY_PLUS,
      KEY_MINUS, KEY_ENTR, KEY_CLR, KEY_NOUN: ok = 1'b1;
      default: ;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dsky_key_fifo.sv
// Synchronous keystroke FIFO. A pop and a push in the same cycle both take
// effect, which also lets a push into a full FIFO succeed when it is popped.
// Ports: clk, rst_n, push_i, pop_i, wdata_i (in); head_c (comb head entry),
// full_o, empty_o (registered status).
module dsky_key_fifo
  import agc_io_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = KEY_CODE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] head_c,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              full_q;
  logic              empty_q;
  logic              do_pop_c;
  logic              do_push_c;

  assign do_pop_c  = pop_i && !empty_q;
  assign do_push_c = push_i && (!full_q || do_pop_c);

  // Occupancy next-state
  always_comb begin
    cnt_d = cnt_q;
    if (do_push_c && !do_pop_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (do_pop_c && !do_push_c) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CNT_W'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage needs no reset; entries are only read while non-empty
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_c  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/dsky_keyboard_encoder.sv
// DSKY keyboard encoder: debounces the raw keypad scanner, queues one
// keystroke per press and offers the head keystroke to the CPU on channel
// 015 with a KEYRUPT1 request/acknowledge handshake.
// Ports: clk, rst_n, key_down, key_code_in, keyrupt_ack, overflow_clr (in);
// keyrupt_req, chan15_data, overflow (out, all registered).
module dsky_keyboard_encoder
  import agc_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned GAP_CYCLES      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_down,
  input  logic [KEY_CODE_W-1:0] key_code_in,
  output logic                  keyrupt_req,
  output logic [AGC_WORD_W-1:0] chan15_data,
  input  logic                  keyrupt_ack,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  localparam int unsigned DB_CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned GAP_CNT_W = $clog2(GAP_CYCLES + 1);

  db_state_e             db_state_q, db_state_d;
  logic [DB_CNT_W-1:0]   db_cnt_q, db_cnt_d;
  logic [KEY_CODE_W-1:0] key_q, key_d;
  logic                  push_q, push_d;

  hs_state_e             hs_state_q, hs_state_d;
  logic [GAP_CNT_W-1:0]  gap_q, gap_d;
  logic                  req_q, req_d;
  chan15_word_t          chan15_q, chan15_d;
  logic                  ovf_q, ovf_d;

  logic                  key_ok_c;
  logic                  pop_c;
  logic                  drop_c;
  logic [KEY_CODE_W-1:0] fifo_head_c;
  logic                  fifo_full;
  logic                  fifo_empty;

  // Invalid codes behave exactly like a released key
  assign key_ok_c = key_down && is_valid_key(key_code_in);

  // Debounce FSM: one push per press, release must be stable before re-arming
  always_comb begin
    db_state_d = db_state_q;
    db_cnt_d   = db_cnt_q;
    key_d      = key_q;
    push_d     = 1'b0;
    unique case (db_state_q)
      DB_IDLE: begin
        if (key_ok_c) begin
          key_d      = key_code_in;
          db_cnt_d   = DB_CNT_W'(1);
          db_state_d = DB_ARM;
        end
      end
      DB_ARM: begin
        if (!key_ok_c || (key_code_in != key_q)) begin
          db_state_d = DB_IDLE;
        end else if (db_cnt_q == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          push_d     = 1'b1;
          db_state_d = DB_HELD;
        end else begin
          db_cnt_d = db_cnt_q + DB_CNT_W'(1);
        end
      end
      DB_HELD: begin
        if (!key_ok_c) begin
          db_cnt_d   = DB_CNT_W'(1);
          db_state_d = DB_RELEASE;
        end
      end
      DB_RELEASE: begin
        if (key_ok_c) begin
          db_state_d = DB_HELD;
        end else if (db_cnt_q == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          db_state_d = DB_IDLE;
        end else begin
          db_cnt_d = db_cnt_q + DB_CNT_W'(1);
        end
      end
    endcase
  end

  // Handshake FSM: registered request and channel word, enforced low gap
  always_comb begin
    hs_state_d = hs_state_q;
    gap_d      = gap_q;
    req_d      = req_q;
    chan15_d   = chan15_q;
    pop_c      = 1'b0;
    unique case (hs_state_q)
      HS_IDLE: begin
        if (!fifo_empty) begin
          req_d         = 1'b1;
          chan15_d.pad  = '0;
          chan15_d.code = fifo_head_c;
          hs_state_d    = HS_REQ;
        end
      end
      HS_REQ: begin
        if (keyrupt_ack) begin
          pop_c      = 1'b1;
          req_d      = 1'b0;
          chan15_d   = '0;
          gap_d      = '0;
          hs_state_d = HS_GAP;
        end
      end
      HS_GAP: begin
        if (gap_q == GAP_CNT_W'(GAP_CYCLES - 1)) begin
          hs_state_d = HS_IDLE;
        end else begin
          gap_d = gap_q + GAP_CNT_W'(1);
        end
      end
      default: hs_state_d = HS_IDLE;
    endcase
  end

  // A simultaneous pop frees the slot, so only an unpopped full FIFO drops
  assign drop_c = push_q && fifo_full && !pop_c;

  always_comb begin
    ovf_d = ovf_q;
    if (drop_c) begin
      ovf_d = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Debounce starts in RELEASE so a key held through reset is not taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_state_q <= DB_RELEASE;
      db_cnt_q   <= '0;
      key_q      <= '0;
      push_q     <= 1'b0;
      hs_state_q <= HS_IDLE;
      gap_q      <= '0;
      req_q      <= 1'b0;
      chan15_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      db_state_q <= db_state_d;
      db_cnt_q   <= db_cnt_d;
      key_q      <= key_d;
      push_q     <= push_d;
      hs_state_q <= hs_state_d;
      gap_q      <= gap_d;
      req_q      <= req_d;
      chan15_q   <= chan15_d;
      ovf_q      <= ovf_d;
    end
  end

  dsky_key_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (KEY_CODE_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_q),
    .pop_i   (pop_c),
    .wdata_i (key_q),
    .head_c  (fifo_head_c),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign keyrupt_req = req_q;
  assign chan15_data = chan15_q;
  assign overflow    = ovf_q;

endmodule
